mcu_multi: RTL

- Parametrised successor to the player master control unit; sequences NUM_SONGS songs and drives the song player's play, fast-forward and reset controls.
- Sits between the button one-pulsers and the song player/reader.
- Adds previous-song (rewind), a fast-forward scan mode, non-power-of-2 song counts and a loop/stop-at-end policy.

---
 rtl/mcu_pkg.sv | 11 +
 rtl/dffre.sv | 18 +
 rtl/song_counter.sv | 40 ++++
 rtl/mcu_multi.sv | 95 +++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the multi-song master control unit.
// The state encoding is fixed; 2'd3 is illegal and recovers to PAUSE.
package mcu_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd0;
  localparam logic [STATE_W-1:0] ST_PLAY  = 2'd1;
  localparam logic [STATE_W-1:0] ST_FFWD  = 2'd2;

endpackage

// File: rtl/dffre.sv
// Resettable flop with load enable.
// Uses an asynchronous active-low reset; it clears to zero.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/song_counter.sv
// Modulo-NUM_SONGS up/down counter for the current song index.
// Priority: clr > inc > dec. Wrap uses compares, not bit overflow.
module song_counter #(
  parameter int NUM_SONGS = 4,
  localparam int W = $clog2(NUM_SONGS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] LAST = W'(NUM_SONGS - 1);

  logic [W-1:0] q_d;
  logic         en;

  assign en = clr | inc | dec;

  always_comb begin
    q_d = q;
    unique case (1'b1)
      clr:     q_d = '0;
      inc:     q_d = (q == LAST) ? '0 : q + 1'b1;
      dec:     q_d = (q == '0) ? LAST : q - 1'b1;
      default: q_d = q;
    endcase
  end

  dffre #(.W(W)) u_q (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (q_d),
    .q     (q)
  );

endmodule

// File: rtl/mcu_multi.sv
// Multi-song master control unit: play/pause/ffwd FSM and song sequencing.
// Define MCU_AUTOPLAY_EN to keep the player running across song changes.
module mcu_multi
  import mcu_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  localparam int SONG_W = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              rewind_button,
  input  logic              ff_button,
  input  logic              loop_all,
  input  logic              song_done,
  output logic              play,
  output logic              ff,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] cur;
  logic [STATE_W-1:0] adv_st;
  logic               inc, dec, clr;
  logic               at_end;

  assign at_end = (song == LAST) && !loop_all;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_PAUSE;
    else        state_q <= state_d;
  end

  // State taken by a non-terminal song advance.
`ifdef MCU_AUTOPLAY_EN
  assign adv_st = (cur == ST_PAUSE) ? ST_PAUSE : ST_PLAY;
`else
  assign adv_st = ST_PAUSE;
`endif

  always_comb begin
    cur          = ST_PAUSE;
    state_d      = ST_PAUSE;
    inc          = 1'b0;
    dec          = 1'b0;
    clr          = 1'b0;
    reset_player = 1'b0;
    if (state_q == ST_PLAY || state_q == ST_FFWD)
      cur = state_q;
    state_d = cur;
    priority case (1'b1)
      next_button: begin
        inc          = 1'b1;
        reset_player = 1'b1;
        state_d      = adv_st;
      end
      rewind_button: begin
        dec          = 1'b1;
        reset_player = 1'b1;
        state_d      = (cur == ST_FFWD) ? ST_PLAY : cur;
      end
      song_done: begin
        reset_player = 1'b1;
        clr          = at_end;
        inc          = !at_end;
        state_d      = at_end ? ST_PAUSE : adv_st;
      end
      ff_button: begin
        if (cur == ST_PLAY)      state_d = ST_FFWD;
        else if (cur == ST_FFWD) state_d = ST_PLAY;
      end
      play_button: begin
        state_d = (cur == ST_PAUSE) ? ST_PLAY : ST_PAUSE;
      end
      default: state_d = cur;
    endcase
  end

  assign play = (state_q == ST_PLAY) || (state_q == ST_FFWD);
  assign ff   = (state_q == ST_FFWD);

  song_counter #(.NUM_SONGS(NUM_SONGS)) u_song (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .clr   (clr),
    .q     (song)
  );

endmodule
